sha_req_arbiter: RTL

SHA_REQ_ARBITER -- requirements
Module: sha_req_arbiter

---
 rtl/sha_arb_pkg.sv | 20 ++
 rtl/rr_select.sv | 39 +++
 rtl/sha_req_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/sha_arb_pkg.sv
// rtl/sha_arb_pkg.sv - shared types and widths for the double-SHA request arbiter
//   state_t     : arbiter FSM states (IDLE, GRANT, LAUNCH, WAIT, RESP)
//   NUM_REQ_DEF : default number of requesters
//   BLOCK_W     : message block width (512)
//   HASH_W      : hash / chaining value width (256)
package sha_arb_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int BLOCK_W     = 512;
  localparam int HASH_W      = 256;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    LAUNCH,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/rr_select.sv
// rtl/rr_select.sv - round-robin winner search starting at a rotating pointer
//   valid  in  NUM_REQ  request lines
//   ptr    in  ID_W     index where the search starts (must be < NUM_REQ)
//   winner out ID_W     first valid index at or after ptr, wrapping
//   any    out 1        at least one request is valid
module rr_select #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    winner,
  output logic               any
);

  // One extra bit so ptr + k (at most 2*NUM_REQ-2) can be folded back
  // modulo NUM_REQ with a single subtract, also for non-power-of-2 counts.
  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;

  always_comb begin
    winner = '0;
    any    = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NUM_REQ)) begin
        sum = sum - (ID_W+1)'(NUM_REQ);
      end
      idx = sum[ID_W-1:0];
      if (!any && valid[idx]) begin
        any    = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/sha_req_arbiter.sv
// rtl/sha_req_arbiter.sv - round-robin arbiter sharing one double-SHA engine
//   Optional watchdog: define SHA_ARB_TIMEOUT_EN to abort jobs after TIMEOUT_CYCLES.
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/ready          per-requester job handshake (ready is a one-hot pulse)
//   req_block/init/hash_in   per-requester job payload, packed by requester index
//   eng_start/block/init_hash/hash_in  job issue to the engine
//   eng_done/hash            engine completion
//   rsp_valid/ready/id/hash/err        result to the consumer
module sha_req_arbiter
  import sha_arb_pkg::*;
#(
  parameter int NUM_REQ        = NUM_REQ_DEF,
  parameter int ID_W           = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*BLOCK_W-1:0] req_block,
  input  logic [NUM_REQ-1:0]        req_init,
  input  logic [NUM_REQ*HASH_W-1:0] req_hash_in,
  output logic                      eng_start,
  output logic [BLOCK_W-1:0]        eng_block,
  output logic                      eng_init_hash,
  output logic [HASH_W-1:0]         eng_hash_in,
  input  logic                      eng_done,
  input  logic [HASH_W-1:0]         eng_hash,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [HASH_W-1:0]         rsp_hash,
  output logic                      rsp_err
);

  state_t          state;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] winner;
  logic            any;
  logic            timeout_hit;

  rr_select #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_select (
    .valid  (req_valid),
    .ptr    (ptr),
    .winner (winner),
    .any    (any)
  );

`ifdef SHA_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wd_cnt;
  logic             err_q;

  // wd_cnt holds the index of the current WAIT cycle, so the last allowed
  // cycle is TIMEOUT_CYCLES-1 and the response rises TIMEOUT_CYCLES cycles
  // after WAIT was entered.
  assign timeout_hit = (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign rsp_err     = err_q;
`else
  // Watchdog compiled out: never fires, WAIT lasts until eng_done.
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
  assign rsp_err     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= '0;
      req_ready     <= '0;
      eng_start     <= 1'b0;
      eng_block     <= '0;
      eng_init_hash <= 1'b0;
      eng_hash_in   <= '0;
      rsp_valid     <= 1'b0;
      rsp_id        <= '0;
      rsp_hash      <= '0;
`ifdef SHA_ARB_TIMEOUT_EN
      wd_cnt        <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      req_ready <= '0;
      eng_start <= 1'b0;
      case (state)
        IDLE: begin
          // The winner's payload is latched on entry to GRANT; the requester
          // still holds it through the accept cycle, so this is the same data.
          if (any) begin
            req_ready     <= NUM_REQ'(1) << winner;
            eng_block     <= req_block[int'(winner)*BLOCK_W +: BLOCK_W];
            eng_init_hash <= req_init[winner];
            eng_hash_in   <= req_hash_in[int'(winner)*HASH_W +: HASH_W];
            rsp_id        <= winner;
            state         <= GRANT;
          end
        end
        GRANT: begin
          // rsp_id already carries the winner for the rest of the job.
          ptr       <= (rsp_id == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id + 1'b1;
          eng_start <= 1'b1;
          state     <= LAUNCH;
        end
        LAUNCH: begin
`ifdef SHA_ARB_TIMEOUT_EN
          wd_cnt <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
`ifdef SHA_ARB_TIMEOUT_EN
          wd_cnt <= wd_cnt + 1'b1;
`endif
          if (eng_done) begin
            rsp_hash  <= eng_hash;
            rsp_valid <= 1'b1;
`ifdef SHA_ARB_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
            state     <= RESP;
          end else if (timeout_hit) begin
            rsp_hash  <= '0;
            rsp_valid <= 1'b1;
`ifdef SHA_ARB_TIMEOUT_EN
            err_q     <= 1'b1;
`endif
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
